// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control/datapath inputs and PC/status outputs of the next-PC stage
interface pc_sequencer_if #(parameter int WIDTH = 32);
  logic             stall;
  logic [2:0]       bj;
  logic             mode;
  logic             alu_zero;
  logic [WIDTH-1:0] rs_data;
  logic [15:0]      imm;
  logic [25:0]      jtarget;
  logic             stat_we;
  logic             stat_z_in;
  logic             stat_n_in;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus4;
  logic             taken;
  logic [1:0]       status;
  logic             illegal;
  modport master (
    output stall, bj, mode, alu_zero, rs_data, imm, jtarget, stat_we, stat_z_in, stat_n_in,
    input  pc, pc_plus4, taken, status, illegal
  );
  modport slave (
    input  stall, bj, mode, alu_zero, rs_data, imm, jtarget, stat_we, stat_z_in, stat_n_in,
    output pc, pc_plus4, taken, status, illegal
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC selection, PC register, {N,Z} status register and sticky illegal-code flag
module pc_sequencer #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input logic            clk,
  input logic            reset,
  pc_sequencer_if.slave  bus
);
  logic [WIDTH-1:0] pc_q, pc_plus4, btarget, jaddr, jsaddr, target, next_pc;
  logic [1:0]       status_q;
  logic             taken_q, illegal_q, go, bad;
  assign pc_plus4 = pc_q + WIDTH'(4);
  assign btarget  = pc_plus4 + {{(WIDTH-18){bus.imm[15]}}, bus.imm, 2'b00};
  assign jaddr    = {pc_plus4[WIDTH-1:28], bus.jtarget, 2'b00};
  assign jsaddr   = {bus.rs_data[WIDTH-1:2], 2'b00};
  // decode {bj,mode} into a redirect condition and its target; undefined codes fall through sequentially
  always_comb begin
    go     = 1'b0;
    bad    = 1'b0;
    target = btarget;
    case ({bus.bj, bus.mode})
      4'b000_0: go = 1'b0;
      4'b001_1: go = status_q[0];
      4'b010_0: begin go = 1'b1; target = jaddr; end
      4'b011_0: begin go = 1'b1; target = jsaddr; end
      4'b101_0: go = bus.rs_data[WIDTH-1];
      4'b110_0: go = bus.alu_zero;
      default:  bad = 1'b1;
    endcase
    next_pc = go ? target : pc_plus4;
  end
  // architectural state; a stalled edge freezes everything except clearing taken
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      status_q  <= 2'b00;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      taken_q <= !bus.stall && go;
      if (!bus.stall) begin
        pc_q <= next_pc;
        if (bus.stat_we) status_q <= {bus.stat_n_in, bus.stat_z_in};
        if (bad) illegal_q <= 1'b1;
      end
    end
  end
  assign bus.pc       = pc_q;
  assign bus.pc_plus4 = pc_plus4;
  assign bus.taken    = taken_q;
  assign bus.status   = status_q;
  assign bus.illegal  = illegal_q;
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Next-PC and fetch-address stage of the single-cycle datapath.
- Consumes the control decoder's branch/jump code {bj2,bj1,bj0} and mode, plus ALU and register-file results.
- Owns the architectural PC register and the 2-bit status register (Z,N) used by the status-based branch (bz).
- Its pc output addresses instruction memory. Instruction memory in turn feeds the opcode to the control decoder.

Parameters:
- WIDTH, 32, PC/data width in bits.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- stall  input  1  1 = hold PC and status; instruction does not retire
- bj  input  3  branch/jump code {bj2,bj1,bj0} from control
- mode  input  1  1 = branch condition taken from status register Z (bz)
- alu_zero  input  1  ALU zero output of the current instruction (beq compare)
- rs_data  input  WIDTH  register-file rs read value
- imm  input  16  instruction[15:0], branch word offset
- jtarget  input  26  instruction[25:0], pseudo-direct jump field
- stat_we  input  1  status write enable (R-format/nori retire)
- stat_z_in  input  1  ALU result == 0 for status update
- stat_n_in  input  1  ALU result[WIDTH-1] for status update
- pc  output  WIDTH  current PC (registered)
- pc_plus4  output  WIDTH  pc+4, combinational; link value for jspal memory write
- taken  output  1  registered; 1 for the cycle after a non-sequential PC update
- status  output  2  registered {N,Z}
- illegal  output  1  sticky; set on an undefined bj/mode combination

Behaviour:
- Reset: on a clk edge with reset=1, all state loads its reset value:
  - pc = RESET_PC
  - status = 2'b00
  - taken = 0
  - illegal = 0
- reset has priority over stall and every other input.
- Single-cycle model: one PC update per non-stalled clock edge.
- Derived values:
  - pc_plus4 = pc + 4, modulo 2^WIDTH.
  - btarget = pc_plus4 + (sign_extend(imm) << 2), modulo 2^WIDTH. Wrap-around is silent.
  - jaddr = {pc_plus4[31:28], jtarget, 2'b00}.
- bj decode, when stall=0 (mode must be 0 except for 001):
  - 000: next = pc_plus4.
  - 001 with mode=1 (bz): next = btarget if status Z == 1, else pc_plus4.
  - 010 (j): next = jaddr.
  - 011 (jspal): next = {rs_data[31:2], 2'b00}. Low two bits are masked; no fault is raised.
  - 101 (bltz): next = btarget if rs_data[31] == 1, else pc_plus4.
  - 110 (beq): next = btarget if alu_zero == 1, else pc_plus4.
- Illegal combinations: bj = 100 or 111, bj = 001 with mode = 0, or mode = 1 with bj != 001.
  - next = pc_plus4.
  - illegal <= 1 and stays 1 until reset.
- taken <= 1 iff stall=0 and next != pc_plus4 by decode (condition true or unconditional jump), else 0. A taken branch whose target equals pc_plus4 still sets taken=1.
- Status register:
  - If stall=0 and stat_we=1, status <= {stat_n_in, stat_z_in} at the clock edge.
  - bz evaluates the pre-edge Z value. An instruction never sees its own status write, and no bypass exists.
- Stall: pc, status and illegal hold; taken <= 0. The bj/stat_we inputs are ignored for that edge.
- Outputs are glitch-free registered values, except pc_plus4.

Test Plan:
- Reset then sequential: reset=1 for 2 cycles, release, bj=000 for 3 cycles -> pc 0,4,8,12; taken=0; illegal=0.
- beq taken/not taken: pc=0x40, bj=110, imm=16'hFFFC, alu_zero=1 -> pc=0x34, taken=1. Repeat with alu_zero=0 -> pc=0x44, taken=0.
- bz ordering: status Z=0, apply an instruction with stat_we=1, stat_z_in=1 -> status=01. Next cycle bz (bj=001, mode=1), imm=2, pc=0x100 -> pc=0x10C. Same-cycle stat_we + bz with old Z=0 -> not taken.
- Jumps: pc=0x8000_0010, j with jtarget=26'h0000040 -> pc=0x8000_0100. jspal with rs_data=0x0000_2003 -> pc=0x0000_2000, pc_plus4 before the edge = link value.
- bltz + wrap: pc=0xFFFF_FFF8, bltz, rs_data=0x8000_0000, imm=1 -> pc=0x0000_0000, taken=1. With rs_data=0x7FFF_FFFF -> pc=0xFFFF_FFFC.
- Stall, illegal, mid-stall reset:
  - stall=1 with bj=010 -> pc, status unchanged; taken=0.
  - bj=111 -> pc+4, illegal=1, held through later legal codes.
  - reset during stall -> pc=RESET_PC, illegal=0.
